// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Provides bus widths, the zero word, chip-enable and reset levels,
// the default reset PC, the fetch FSM state encoding and the
// {pc, inst} queue entry. The HALT state exists only when
// IF_MISALIGN_CHECK_EN is defined.
package if_fetch_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;
  localparam int unsigned ENTRY_W     = INST_ADDR_W + INST_W;

  localparam logic [INST_W-1:0]      ZERO_WORD        = '0;
  localparam logic                   CHIP_ENABLE      = 1'b1;
  localparam logic                   CHIP_DISABLE     = 1'b0;
  localparam logic                   RST_ENABLE       = 1'b1;
  localparam logic [INST_ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
`ifdef IF_MISALIGN_CHECK_EN
    ,
    ST_HALT = 2'd2
`endif
  } fetch_state_e;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_entry_t;

  // Clears the byte-offset bits so the ROM only ever sees word addresses.
  function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
    return {addr[INST_ADDR_W-1:2], 2'b00};
  endfunction

`ifdef IF_MISALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [INST_ADDR_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction
`endif

endpackage

// File: rtl/if_fetch_queue.sv
// Synchronous FIFO holding fetched {pc, inst} entries.
// Ports: clk, rst (sync, active-high), push/pop/flush controls,
// push_data in, head_data (entry at the read pointer, raw), count.
// Push while full is accepted only together with a pop; flush wins
// over push and pop. DEPTH must be a power of two and >= 2.
module if_fetch_queue
  import if_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = ENTRY_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full queue still takes a push when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop & (count != '0);
    do_push = push & ((count < CNT_W'(DEPTH)) | do_pop);
  end

  // Pointer and occupancy state; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage array, no reset needed: validity is tracked by count.
  always_ff @(posedge clk) begin
    if (rst != RST_ENABLE && !flush && do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch initiator: owns the PC, drives the instruction ROM
// (combinational read data) and queues {pc, inst} pairs for decode over
// a valid/ready handshake. Redirects from EX flush the queue and reload PC.
// Ports:
//   clk, rst (sync active-high)
//   rom_ce_o, rom_addr_o, rom_inst_i        ROM interface
//   branch_flag_i, branch_target_i          redirect from EX
//   id_ready_i, if_valid_o, if_pc_o,
//   if_inst_o, if_count_o                   decode handshake / debug
// Optional: IF_MISALIGN_CHECK_EN adds if_misalign_o / if_bad_addr_o and a
// HALT state entered on a misaligned redirect target.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned            QUEUE_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           rom_ce_o,
  output logic [INST_ADDR_W-1:0]         rom_addr_o,
  input  logic [INST_W-1:0]              rom_inst_i,
  input  logic                           branch_flag_i,
  input  logic [INST_ADDR_W-1:0]         branch_target_i,
  input  logic                           id_ready_i,
  output logic                           if_valid_o,
  output logic [INST_ADDR_W-1:0]         if_pc_o,
  output logic [INST_W-1:0]              if_inst_o,
`ifdef IF_MISALIGN_CHECK_EN
  output logic                           if_misalign_o,
  output logic [INST_ADDR_W-1:0]         if_bad_addr_o,
`endif
  output logic [$clog2(QUEUE_DEPTH):0]   if_count_o
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e           state_q;
  fetch_state_e           state_d;
  logic [INST_ADDR_W-1:0] pc_q;
  logic [INST_ADDR_W-1:0] pc_d;
  logic                   ce_q;
  logic                   push;
  logic                   pop;
  logic [CNT_W-1:0]       count;
  logic [ENTRY_W-1:0]     head_raw;
  fetch_entry_t           head;
  fetch_entry_t           new_entry;

`ifdef IF_MISALIGN_CHECK_EN
  logic                   misalign_q;
  logic [INST_ADDR_W-1:0] bad_addr_q;
  logic                   bad_redirect;
`endif

  // Next state, handshake decode and next PC.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pop       = if_valid_o & id_ready_i;
    push      = 1'b0;
    new_entry = '{pc: pc_q, inst: rom_inst_i};

    unique case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
`ifdef IF_MISALIGN_CHECK_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_IDLE;
    endcase

`ifdef IF_MISALIGN_CHECK_EN
    bad_redirect = branch_flag_i & is_misaligned(branch_target_i);
    if (bad_redirect) state_d = ST_HALT;
`endif

    // Redirect beats push; the ROM word read this cycle is dropped.
    push = (state_q == ST_RUN) & ~branch_flag_i & ((count < CNT_W'(QUEUE_DEPTH)) | pop);

    if (branch_flag_i)  pc_d = word_align(branch_target_i);
    else if (push)      pc_d = pc_q + 32'd4;
  end

  // State, PC and chip-enable registers.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ce_q    <= CHIP_DISABLE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ce_q    <= (state_d == ST_RUN) ? CHIP_ENABLE : CHIP_DISABLE;
    end
  end

`ifdef IF_MISALIGN_CHECK_EN
  // Sticky error flag; keeps the first offending target.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
    end else if (bad_redirect && !misalign_q) begin
      misalign_q <= 1'b1;
      bad_addr_q <= branch_target_i;
    end
  end

  assign if_misalign_o = misalign_q;
  assign if_bad_addr_o = bad_addr_q;
`endif

  if_fetch_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (branch_flag_i),
    .push_data (new_entry),
    .head_data (head_raw),
    .count     (count)
  );

  assign head       = fetch_entry_t'(head_raw);
  assign rom_ce_o   = ce_q;
  assign rom_addr_o = pc_q;
  assign if_count_o = count;
  assign if_valid_o = (count != '0);
  // Empty queue presents zeros rather than stale storage.
  assign if_pc_o    = if_valid_o ? head.pc   : '0;
  assign if_inst_o  = if_valid_o ? head.inst : ZERO_WORD;

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch. The ROM model returns word index
// (addr >> 2). Expected consumed {pc, inst} pairs are queued by the
// stimulus; a negedge monitor pops one per valid&ready handshake.
module tb_if_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [1:0]  if_count;
`ifdef IF_MISALIGN_CHECK_EN
  logic        if_misalign;
  logic [31:0] if_bad_addr;
`endif

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  assign rom_inst = rom_addr >> 2;

  if_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .rom_ce_o        (rom_ce),
    .rom_addr_o      (rom_addr),
    .rom_inst_i      (rom_inst),
    .branch_flag_i   (branch_flag),
    .branch_target_i (branch_target),
    .id_ready_i      (id_ready),
    .if_valid_o      (if_valid),
    .if_pc_o         (if_pc),
    .if_inst_o       (if_inst),
`ifdef IF_MISALIGN_CHECK_EN
    .if_misalign_o   (if_misalign),
    .if_bad_addr_o   (if_bad_addr),
`endif
    .if_count_o      (if_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_item(input logic [31:0] pc, input logic [31:0] inst);
    exp_q.push_back('{pc: pc, inst: inst});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && if_valid && id_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got pc 0x%08h inst 0x%08h, none expected", if_pc, if_inst);
      end else begin
        e = exp_q.pop_front();
        if (if_pc !== e.pc || if_inst !== e.inst) begin
          fails++;
          $display("FAIL pop_data: got pc 0x%08h inst 0x%08h expected pc 0x%08h inst 0x%08h",
                   if_pc, if_inst, e.pc, e.inst);
        end
      end
    end
  end

  initial begin
    rst           = 1'b1;
    id_ready      = 1'b1;
    branch_flag   = 1'b0;
    branch_target = 32'h0;
    tick();
    tick();
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_ce",    32'(rom_ce),   32'd0);
    chk("rst_count", 32'(if_count), 32'd0);
    chk("rst_pc",    if_pc,         32'd0);
    chk("rst_inst",  if_inst,       32'd0);
    chk("rst_addr",  rom_addr,      32'd0);

    // Streaming with decode always ready
    expect_item(32'h0, 32'd0);
    expect_item(32'h4, 32'd1);
    expect_item(32'h8, 32'd2);
    rst = 1'b0;
    tick();
    chk("e0_ce",    32'(rom_ce),   32'd1);
    chk("e0_valid", 32'(if_valid), 32'd0);
    tick();
    chk("e1_valid", 32'(if_valid), 32'd1);
    chk("e1_pc",    if_pc,         32'h0);
    tick();
    chk("stream_count", 32'(if_count), 32'd1);
    tick();
    tick();

    // Mid-stream reset for one cycle
    id_ready = 1'b0;
    rst      = 1'b1;
    tick();
    chk("mrst_valid", 32'(if_valid), 32'd0);
    chk("mrst_ce",    32'(rom_ce),   32'd0);
    chk("mrst_count", 32'(if_count), 32'd0);
    chk("mrst_addr",  rom_addr,      32'h0);
    rst = 1'b0;
    tick();
    chk("restart_ce",   32'(rom_ce), 32'd1);
    chk("restart_addr", rom_addr,    32'h0);
    tick();
    chk("restart_valid", 32'(if_valid), 32'd1);
    chk("restart_pc",    if_pc,         32'h0);

    // Decode stalls five cycles: queue fills, PC holds
    expect_item(32'h0, 32'd0);
    expect_item(32'h4, 32'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("stall_count", 32'(if_count), 32'd2);
    chk("stall_addr",  rom_addr,      32'h8);
    chk("stall_head",  if_pc,         32'h0);
    id_ready = 1'b1;
    tick();
    chk("full_pushpop_count", 32'(if_count), 32'd2);
    chk("full_pushpop_head",  if_pc,         32'h4);
    chk("full_pushpop_addr",  rom_addr,      32'hC);
    tick();

    // Redirect with two entries queued, no pop
    id_ready      = 1'b0;
    branch_flag   = 1'b1;
    branch_target = 32'h40;
    tick();
    branch_flag = 1'b0;
    chk("redir_count", 32'(if_count), 32'd0);
    chk("redir_addr",  rom_addr,      32'h40);
    chk("redir_valid", 32'(if_valid), 32'd0);
    tick();
    chk("redir_tgt_valid", 32'(if_valid), 32'd1);
    chk("redir_tgt_pc",    if_pc,         32'h40);
    chk("redir_tgt_inst",  if_inst,       32'd16);
    tick();
    chk("refill_count", 32'(if_count), 32'd2);

    // Redirect and pop in the same cycle
    expect_item(32'h40, 32'd16);
    expect_item(32'h80, 32'd32);
    expect_item(32'h84, 32'd33);
    expect_item(32'h88, 32'd34);
    id_ready      = 1'b1;
    branch_flag   = 1'b1;
    branch_target = 32'h80;
    tick();
    branch_flag = 1'b0;
    chk("rpop_count", 32'(if_count), 32'd0);
    chk("rpop_addr",  rom_addr,      32'h80);
    tick();
    chk("rpop_head", if_pc, 32'h80);
    tick();
    tick();
    tick();
    id_ready = 1'b0;

    // PC wraps past 0xFFFF_FFFC
    branch_flag   = 1'b1;
    branch_target = 32'hFFFF_FFF8;
    tick();
    branch_flag = 1'b0;
    id_ready    = 1'b1;
    expect_item(32'hFFFF_FFF8, 32'h3FFF_FFFE);
    expect_item(32'hFFFF_FFFC, 32'h3FFF_FFFF);
    expect_item(32'h0000_0000, 32'h0);
    tick();
    chk("wrap_head", if_pc, 32'hFFFF_FFF8);
    tick();
    tick();
    chk("wrap_addr", rom_addr, 32'h4);
    tick();
    id_ready = 1'b0;
    chk("wrap_addr2", rom_addr, 32'h8);

    // Misaligned redirect target
    branch_flag   = 1'b1;
    branch_target = 32'h42;
    tick();
    branch_flag = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
    chk("mis_flag",  32'(if_misalign), 32'd1);
    chk("mis_addr",  if_bad_addr,      32'h42);
    chk("mis_ce",    32'(rom_ce),      32'd0);
    chk("mis_count", 32'(if_count),    32'd0);
    id_ready = 1'b1;
    tick();
    tick();
    chk("halt_valid", 32'(if_valid),    32'd0);
    chk("halt_flag",  32'(if_misalign), 32'd1);
    chk("halt_ce",    32'(rom_ce),      32'd0);
    chk("halt_addr",  rom_addr,         32'h40);
`else
    chk("mis_addr",  rom_addr,      32'h40);
    chk("mis_count", 32'(if_count), 32'd0);
    chk("mis_ce",    32'(rom_ce),   32'd1);
    id_ready = 1'b1;
    expect_item(32'h40, 32'd16);
    expect_item(32'h44, 32'd17);
    tick();
    chk("mis_head", if_pc, 32'h40);
    tick();
    tick();
    id_ready = 1'b0;
    tick();
`endif

    chk("scoreboard_left", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch initiator for the in-order RISC-V pipeline.
- Owns the PC and drives the chip-enable and address of the instruction ROM. The ROM returns the instruction combinationally in the same cycle.
- Buffers {pc, inst} pairs in a small queue and hands them to the decode stage over a valid/ready handshake.
- Accepts branch/jump redirects from EX, which flush all in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
QUEUE_DEPTH, 2, fetch-queue entries; power of two, >= 2.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
rom_ce_o  output  1  ROM chip enable (`ChipEnable / `ChipDisable).
rom_addr_o  output  `InstAddrBus (32)  byte address to ROM; always equals the PC register.
rom_inst_i  input  `InstBus (32)  ROM read data, valid in the same cycle as rom_addr_o.
branch_flag_i  input  1  redirect request from EX.
branch_target_i  input  32  redirect byte address.
id_ready_i  input  1  decode can accept an instruction this cycle.
if_valid_o  output  1  queue head is valid.
if_pc_o  output  32  queue head PC.
if_inst_o  output  32  queue head instruction.
if_count_o  output  $clog2(QUEUE_DEPTH)+1  occupancy, for debug and performance counters.

Behaviour:
- Reset (rst=1 at an edge):
  - pc <= RESET_PC; rom_ce_o <= `ChipDisable; queue emptied.
  - if_valid_o=0, if_pc_o=0, if_inst_o=`ZeroWord, if_count_o=0.
- Reset applied mid-operation discards all queue contents and any pending redirect.
- State machine, two states:
  - IDLE: ce=0. Moves to RUN on the first edge with rst=0.
  - RUN: ce=1. Returns to IDLE only via rst.
- Handshake signals:
  - pop = if_valid_o & id_ready_i.
  - push = (state==RUN) & ~branch_flag_i & (count<QUEUE_DEPTH | pop).
- Push: enqueues {pc, rom_inst_i} and sets pc <= pc+4. Arithmetic is 32-bit modulo; 0xFFFF_FFFC wraps to 0.
- Stalls: when push=0 and there is no redirect, pc holds and ROM reads repeat.
- Simultaneous push and pop at full: legal; count is unchanged and there is no loss.
- Redirect (branch_flag_i=1 in RUN or IDLE):
  - Next edge: queue cleared, pc <= branch_target_i.
  - The current-cycle ROM word is discarded.
  - A pop asserted in the same cycle still completes; the consumer has already taken the head.
  - Redirect has priority over push; rst has priority over redirect.
- Outputs:
  - if_valid_o = (count!=0); if_pc_o and if_inst_o are the queue head.
  - When empty, if_pc_o=0 and if_inst_o=`ZeroWord.
- Latency:
  - rst falls before edge E0 -> ce=1 after E0 -> first push at E1 -> if_valid_o=1 after E1.
  - Redirect at edge En -> target instruction valid after En+1.
- Throughput: 1 instruction/cycle while id_ready_i=1.
- ROM indexing uses addr[ log2(InstMemNum)+1 : 2 ]. This block always issues word-aligned addresses.

Optional Feature:
- Macro: IF_MISALIGN_CHECK_EN.
- Enabled:
  - A redirect with branch_target_i[1:0]!=0 sets output if_misalign_o=1 (sticky until rst) and latches the target in if_bad_addr_o[31:0].
  - The FSM enters a third state HALT: ce=0, no pushes, queue drains normally.
- Disabled:
  - Target bits [1:0] are forced to 0 on load.
  - The extra ports and the HALT state do not exist.

Decomposition:
- Shared define file: `InstAddrBus, `InstBus, `ZeroWord, `ChipEnable/`ChipDisable, `RstEnable, RESET_PC default, FSM state encodings.
- Sub-module fetch_queue: synchronous FIFO with push, pop, flush, head data, count, and simultaneous push/pop at full. Parameterised by width (64) and depth.

Test Plan:
- Reset release, id_ready_i=1, ROM word[i]=i -> if_valid_o rises 2 edges after release; outputs (pc 0,inst 0),(4,1),(8,2)… one per cycle.
- id_ready_i=0 for 5 cycles after first valid -> count saturates at 2; pc holds at 8; rom_addr_o=8 stable; on release the sequence resumes with pc 0,4,8 and no gaps or duplicates.
- branch_flag_i=1 with target 0x40 while the queue holds 2 entries -> next cycle count=0, rom_addr_o=0x40; one cycle later head is (0x40, word 16).
- Redirect and pop in the same cycle -> the popped entry is consumed exactly once; no stale entries after the flush.
- rst asserted mid-stream for 1 cycle -> if_valid_o=0 and rom_ce_o=0 next cycle; fetch restarts at RESET_PC.
- With IF_MISALIGN_CHECK_EN, target 0x42 -> if_misalign_o=1, if_bad_addr_o=0x42, rom_ce_o=0; without the macro, fetch resumes at 0x40.
